// File: rtl/siaminer_dispatch.sv
// ---------------------------------------------------------------------------------------------
// siaminer_dispatch
//   Multi-core work dispatcher between the UART command parser and NCORES siacores.
//   One accepted work packet (header + target) is latched and shared by all cores.
//   The 32-bit nonce space is split evenly, and every core is started in the same cycle.
//   Found nonces and the final "all ranges exhausted" event pass through a round-robin
//   arbiter into a first-word fall-through result FIFO that feeds the TX framer.
//   Every job carries a 4-bit tag, so results left over from superseded work are discarded.
//
// Build option:
//   SIAMINER_STOP_ON_FIRST_EN - when defined, the first reported nonce of a job aborts all
//                               cores and closes the job. No exhausted entry is produced.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   work_in/target_in        parsed work header and target
//   work_valid/work_ready    work handshake (work_ready is registered)
//   core_work/core_target    latched work and target, shared by all cores
//   core_base                per-core start nonce, core i at [i*NONCE_W +: NONCE_W]
//   core_start/core_abort    1-cycle per-core start and abort pulses
//   core_found/core_nonce    per-core nonce-found pulse and the nonce that goes with it
//   core_done                per-core range-exhausted pulse
//   res_valid/res_ready      result handshake
//   res_nonce/res_kind       result payload (kind 0 = nonce found, 1 = exhausted)
//   busy                     a job is in LOAD or RUN
// ---------------------------------------------------------------------------------------------
module siaminer_dispatch #(
    parameter int unsigned NCORES     = 4,
    parameter int unsigned WORK_W     = 640,
    parameter int unsigned TARGET_W   = 32,
    parameter int unsigned NONCE_W    = 32,
    parameter int unsigned NONCE_OFS  = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WORK_W-1:0]         work_in,
    input  logic [TARGET_W-1:0]       target_in,
    input  logic                      work_valid,
    output logic                      work_ready,
    output logic [WORK_W-1:0]         core_work,
    output logic [TARGET_W-1:0]       core_target,
    output logic [NCORES*NONCE_W-1:0] core_base,
    output logic [NCORES-1:0]         core_start,
    output logic [NCORES-1:0]         core_abort,
    input  logic [NCORES-1:0]         core_found,
    input  logic [NCORES*NONCE_W-1:0] core_nonce,
    input  logic [NCORES-1:0]         core_done,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [NONCE_W-1:0]        res_nonce,
    output logic                      res_kind,
    output logic                      busy
);

    localparam int unsigned IW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int unsigned FW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = NONCE_W + 1;
    // Size of each core's slice of the nonce space. For NCORES=1 this truncates to 0, which
    // is harmless because only core 0 exists.
    localparam logic [NONCE_W-1:0] Step = NONCE_W'((64'd1 << NONCE_W) / 64'(NCORES));

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

    state_e                    state_q, state_d;
    logic [3:0]                job_id_q;
    logic [WORK_W-1:0]         work_q;
    logic [TARGET_W-1:0]       target_q;
    logic [NCORES*NONCE_W-1:0] base_q;
    logic [NCORES-1:0]         start_q, abort_q;
    logic                      work_ready_q, busy_q;

    logic [NCORES-1:0]         pend_q, done_mask_q;
    logic [NONCE_W-1:0]        pend_nonce_q [NCORES];
    logic [3:0]                pend_tag_q   [NCORES];
    logic [IW-1:0]             rr_ptr_q;

    logic [EW-1:0]             fifo_q [FIFO_DEPTH];
    logic [FW:0]               wr_ptr_q, rd_ptr_q;

    logic                      accept, in_run, fifo_empty, fifo_full, pop, can_push;
    logic                      push_found, push_exh, push_en, stop_first;
    logic [EW-1:0]             push_data;
    logic [NCORES-1:0]         tag_ok;
    logic                      grant_vld;
    logic [IW-1:0]             grant_idx, grant_nxt, cand;
    logic [NONCE_W-1:0]        nonce_raw, base_swap;

    // Round-robin arbiter: the first pending entry of the current job at or after rr_ptr_q.
    always_comb begin
        tag_ok    = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NCORES; i++) begin
            tag_ok[i] = pend_q[i] && (pend_tag_q[i] == job_id_q);
        end
        for (int k = 0; k < NCORES; k++) begin
            cand = IW'((32'(rr_ptr_q) + 32'(k)) % NCORES);
            if (!grant_vld && tag_ok[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        grant_nxt = IW'((32'(grant_idx) + 32'd1) % NCORES);
    end

    // The nonce field of the header is stored byte-swapped.
    always_comb begin
        nonce_raw = work_q[NONCE_OFS +: NONCE_W];
        base_swap = '0;
        for (int b = 0; b < NONCE_W / 8; b++) begin
            base_swap[8*b +: 8] = nonce_raw[NONCE_W - 8 - 8*b +: 8];
        end
    end

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[FW] != rd_ptr_q[FW]) &&
                     (wr_ptr_q[FW-1:0] == rd_ptr_q[FW-1:0]);
        pop        = !fifo_empty && res_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
        can_push   = !fifo_full || pop;
        accept     = work_valid && work_ready_q;
        in_run     = (state_q == StRun);
        push_found = in_run && grant_vld && can_push;
        // Exhausted closes the job only once every found nonce has been queued.
        push_exh   = in_run && !accept && (&done_mask_q) && (pend_q == '0) &&
                     (core_found == '0) && can_push;
`ifdef SIAMINER_STOP_ON_FIRST_EN
        stop_first = push_found;
`else
        stop_first = 1'b0;
`endif
        push_en    = push_found || push_exh;
        push_data  = push_exh ? {1'b1, {NONCE_W{1'b0}}} : {1'b0, pend_nonce_q[grant_idx]};

        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StLoad;
            StLoad:  state_d = StRun;
            StRun: begin
                if (accept) begin
                    state_d = StLoad;
                end else if (stop_first || push_exh) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            job_id_q     <= '0;
            work_q       <= '0;
            target_q     <= '0;
            base_q       <= '0;
            start_q      <= '0;
            abort_q      <= '0;
            work_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            pend_q       <= '0;
            done_mask_q  <= '0;
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < NCORES; i++) begin
                pend_nonce_q[i] <= '0;
                pend_tag_q[i]   <= '0;
            end
            for (int d = 0; d < FIFO_DEPTH; d++) begin
                fifo_q[d] <= '0;
            end
        end else begin
            state_q      <= state_d;
            work_ready_q <= (state_d != StLoad);
            busy_q       <= (state_d != StIdle);
            start_q      <= '0;
            abort_q      <= '0;

            if (accept) begin
                work_q   <= work_in;
                target_q <= target_in;
                job_id_q <= job_id_q + 4'd1;
                // New work in RUN preempts the cores still working on the old job.
                if (in_run) abort_q <= '1;
            end

            if (state_q == StLoad) begin
                for (int i = 0; i < NCORES; i++) begin
                    base_q[i*NONCE_W +: NONCE_W] <= base_swap + NONCE_W'(i) * Step;
                end
                start_q     <= '1;
                pend_q      <= '0;
                done_mask_q <= '0;
            end

            if (in_run) begin
                done_mask_q <= done_mask_q | core_done;
                for (int i = 0; i < NCORES; i++) begin
                    if (pend_q[i] && !tag_ok[i]) pend_q[i] <= 1'b0;
                end
                if (push_found) begin
                    pend_q[grant_idx] <= 1'b0;
                    rr_ptr_q          <= grant_nxt;
                end
                // A fresh found overrides the clear above: last nonce wins.
                for (int i = 0; i < NCORES; i++) begin
                    if (core_found[i]) begin
                        pend_q[i]       <= 1'b1;
                        pend_nonce_q[i] <= core_nonce[i*NONCE_W +: NONCE_W];
                        pend_tag_q[i]   <= job_id_q;
                    end
                end
                if (stop_first) begin
                    abort_q <= '1;
                    pend_q  <= '0;
                end
            end

            if (push_en) begin
                fifo_q[wr_ptr_q[FW-1:0]] <= push_data;
                wr_ptr_q                 <= wr_ptr_q + (FW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (FW+1)'(1);
            end
        end
    end

    assign work_ready            = work_ready_q;
    assign core_work             = work_q;
    assign core_target           = target_q;
    assign core_base             = base_q;
    assign core_start            = start_q;
    assign core_abort            = abort_q;
    assign busy                  = busy_q;
    assign res_valid             = !fifo_empty;
    assign {res_kind, res_nonce} = fifo_q[rd_ptr_q[FW-1:0]];

endmodule

// File: tb/tb_siaminer_dispatch.sv
module tb_siaminer_dispatch;

    logic         clk = 1'b0;
    logic         rst;
    logic [639:0] work_in;
    logic [31:0]  target_in;
    logic         work_valid;
    logic         work_ready;
    logic [639:0] core_work;
    logic [31:0]  core_target;
    logic [127:0] core_base;
    logic [3:0]   core_start, core_abort, core_found, core_done;
    logic [127:0] core_nonce;
    logic         res_valid, res_ready, res_kind, busy;
    logic [31:0]  res_nonce;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    siaminer_dispatch #(
        .NCORES    (4),
        .WORK_W    (640),
        .TARGET_W  (32),
        .NONCE_W   (32),
        .NONCE_OFS (256),
        .FIFO_DEPTH(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .work_in    (work_in),
        .target_in  (target_in),
        .work_valid (work_valid),
        .work_ready (work_ready),
        .core_work  (core_work),
        .core_target(core_target),
        .core_base  (core_base),
        .core_start (core_start),
        .core_abort (core_abort),
        .core_found (core_found),
        .core_nonce (core_nonce),
        .core_done  (core_done),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_nonce  (res_nonce),
        .res_kind   (res_kind),
        .busy       (busy)
    );

    typedef struct {
        logic [31:0]  base;
        logic [127:0] exp_base;  // {core3, core2, core1, core0}
    } vec_t;

    vec_t vecs [3];

    // Outputs are read 1 time unit after the active edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [127:0] split4(input logic [31:0] b);
        return {b + 32'hC000_0000, b + 32'h8000_0000, b + 32'h4000_0000, b};
    endfunction

    task automatic send_work(input string tag, input logic [31:0] base,
                             input logic [127:0] exp_base, input logic [3:0] exp_abort);
        logic [639:0] w;
        w = {20{32'h5A3C_96E1}};
        w[256 +: 32] = bswap(base);
        check({tag, " ready before"}, work_ready, 1);
        work_in    = w;
        target_in  = 32'h0000_FFFF ^ base;
        work_valid = 1'b1;
        tick();
        work_valid = 1'b0;
        check({tag, " load ready"}, work_ready, 0);
        check({tag, " load busy"}, busy, 1);
        check({tag, " load start"}, core_start, 0);
        check({tag, " abort"}, core_abort, exp_abort);
        tick();
        check({tag, " start"}, core_start, 4'hF);
        check({tag, " base"}, core_base, exp_base);
        check({tag, " work"}, core_work == w, 1);
        check({tag, " target"}, core_target, 32'h0000_FFFF ^ base);
        check({tag, " run ready"}, work_ready, 1);
        tick();
        check({tag, " start pulse"}, core_start, 0);
        check({tag, " abort pulse"}, core_abort, 0);
    endtask

    task automatic pulse_found(input logic [3:0] mask, input logic [127:0] nonces);
        core_found = mask;
        core_nonce = nonces;
        tick();
        core_found = '0;
        core_nonce = '0;
    endtask

    task automatic pulse_done(input logic [3:0] mask);
        core_done = mask;
        tick();
        core_done = '0;
    endtask

    task automatic expect_result(input string name, input logic [31:0] nonce, input logic kind);
        int n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, " valid"}, res_valid, 1);
        check({name, " nonce"}, res_nonce, nonce);
        check({name, " kind"}, res_kind, kind);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic finish_job(input string tag);
        pulse_done(4'hF);
        expect_result({tag, " exh"}, 32'h0, 1'b1);
        check({tag, " busy after exh"}, busy, 0);
        check({tag, " ready after exh"}, work_ready, 1);
        tick();
        tick();
        check({tag, " single exh"}, res_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rst ready", work_ready, 0);
        check("rst busy", busy, 0);
        check("rst start", core_start, 0);
        check("rst abort", core_abort, 0);
        check("rst base", core_base, 0);
        check("rst work", core_work == '0, 1);
        check("rst res_valid", res_valid, 0);
        rst = 1'b0;
        tick();
        check("post rst ready", work_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0000, {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000}};
        vecs[1] = '{32'hF000_0000, {32'hB000_0000, 32'h7000_0000, 32'h3000_0000, 32'hF000_0000}};
        vecs[2] = '{32'h1234_5678, {32'hD234_5678, 32'h9234_5678, 32'h5234_5678, 32'h1234_5678}};

        work_in    = '0;
        target_in  = '0;
        work_valid = 1'b0;
        core_found = '0;
        core_nonce = '0;
        core_done  = '0;
        res_ready  = 1'b0;
        do_reset();

        // Base split and exhausted-only jobs.
        for (int v = 0; v < 3; v++) begin
            send_work($sformatf("vec%0d", v), vecs[v].base, vecs[v].exp_base, 4'h0);
            finish_job($sformatf("vec%0d", v));
        end

        // Wrapped bases, single found on core 2.
        send_work("t2", 32'hF000_0000, split4(32'hF000_0000), 4'h0);
        pulse_found(4'b0100, {32'h0, 32'h9000_0010, 32'h0, 32'h0});
        expect_result("t2 found", 32'h9000_0010, 1'b0);
        finish_job("t2");

        // Reset in the middle of a job: no abort, everything back to reset values.
        send_work("midrst", 32'h0, split4(32'h0), 4'h0);
        do_reset();

        // Four simultaneous founds against a 2-deep FIFO that is not being drained.
        send_work("t3", 32'h0, split4(32'h0), 4'h0);
        pulse_found(4'hF, {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000});
        for (int i = 0; i < 4; i++) tick();
        check("t3 held valid", res_valid, 1);
        check("t3 held busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            expect_result($sformatf("t3 r%0d", i), 32'hA000_0000 + 32'(i), 1'b0);
        end
        finish_job("t3");

        // Preemption while core 1's nonce waits behind a full FIFO.
        send_work("t5a", 32'h0, split4(32'h0), 4'h0);
        pulse_found(4'b0101, {32'h0, 32'h0000_00B2, 32'h0, 32'h0000_00B0});
        tick();
        tick();
        tick();
        pulse_found(4'b0010, {32'h0, 32'h0, 32'hDEAD_0001, 32'h0});
        tick();
        tick();
        send_work("t5b", 32'h1111_1111, split4(32'h1111_1111), 4'hF);
        expect_result("t5 r0", 32'h0000_00B0, 1'b0);
        expect_result("t5 r1", 32'h0000_00B2, 1'b0);
        tick();
        tick();
        tick();
        check("t5 stale dropped", res_valid, 0);
        finish_job("t5");

        // Two founds three cycles apart.
        send_work("t6", 32'h0, split4(32'h0), 4'h0);
        pulse_found(4'b0001, {32'h0, 32'h0, 32'h0, 32'h0000_0011});
        tick();
`ifdef SIAMINER_STOP_ON_FIRST_EN
        check("t6 stop abort", core_abort, 4'hF);
        check("t6 stop busy", busy, 0);
        check("t6 stop ready", work_ready, 1);
        tick();
        pulse_found(4'b1000, {32'h0000_0033, 32'h0, 32'h0, 32'h0});
        expect_result("t6 r0", 32'h0000_0011, 1'b0);
        tick();
        tick();
        tick();
        check("t6 stop single", res_valid, 0);
`else
        check("t6 no abort", core_abort, 4'h0);
        check("t6 still busy", busy, 1);
        tick();
        pulse_found(4'b1000, {32'h0000_0033, 32'h0, 32'h0, 32'h0});
        expect_result("t6 r0", 32'h0000_0011, 1'b0);
        expect_result("t6 r1", 32'h0000_0033, 1'b0);
        finish_job("t6");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
